// File: rtl/punc_control.sv
// PUNC control unit: FETCH/DECODE/EXEC/EXEC2/HALT sequencer. All datapath
// strobes and selects are decoded combinationally from the state and the IR.
module punc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    output logic        mem_w_en,
    output logic [1:0]  mem_w_addr_sel,
    output logic        mem_w_data_sel,
    output logic [1:0]  mem_r_addr_sel,
    output logic        rf_w_en,
    output logic        rf_r0_addr_sel,
    output logic        rf_r1_addr_sel,
    output logic [1:0]  rf_w_data_sel,
    output logic        rf_w_addr_sel,
    output logic        ir_ld,
    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic [1:0]  pc_ld_data_sel,
    output logic [2:0]  alu_sel,
    output logic        cond_ld,
    output logic        cond_ld_data_sel,
    output logic        ldi_reg_ld,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_EXEC2  = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_ADD_I = 3'd1;
    localparam logic [2:0] ALU_NOT   = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_AND_I = 3'd4;

    state_t     state_q, state_d;
    logic [3:0] opcode;
    logic       br_taken;
    logic       unused_ir;

    assign opcode    = ir[15:12];
    assign br_taken  = (n & ir[11]) | (z & ir[10]) | (p & ir[9]);
    assign unused_ir = ^{ir[8:6], ir[4:0]};

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        mem_w_en         = 1'b0;
        mem_w_addr_sel   = 2'd0;
        mem_w_data_sel   = 1'b0;
        mem_r_addr_sel   = 2'd0;
        rf_w_en          = 1'b0;
        rf_r0_addr_sel   = 1'b0;
        rf_r1_addr_sel   = 1'b0;
        rf_w_data_sel    = 2'd0;
        rf_w_addr_sel    = 1'b0;
        ir_ld            = 1'b0;
        pc_ld            = 1'b0;
        pc_clr           = 1'b0;
        pc_inc           = 1'b0;
        pc_ld_data_sel   = 2'd0;
        alu_sel          = 3'd0;
        cond_ld          = 1'b0;
        cond_ld_data_sel = 1'b0;
        ldi_reg_ld       = 1'b0;
        halted           = 1'b0;

        // Reset dominates every state, so an in-flight write is dropped.
        if (rst) begin
            pc_clr  = 1'b1;
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ir_ld   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    state_d = (opcode == OP_HALT) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    state_d = (opcode == OP_LDI) ? S_EXEC2 : S_FETCH;
                    case (opcode)
                        OP_ADD, OP_AND, OP_NOT: begin
                            if (opcode == OP_NOT)      alu_sel = ALU_NOT;
                            else if (opcode == OP_ADD) alu_sel = ir[5] ? ALU_ADD_I : ALU_ADD;
                            else                       alu_sel = ir[5] ? ALU_AND_I : ALU_AND;
                            rf_w_en = 1'b1;
                            cond_ld = 1'b1;
                        end
                        OP_LD, OP_LDR: begin
                            mem_r_addr_sel   = (opcode == OP_LD) ? 2'd1 : 2'd2;
                            rf_w_en          = 1'b1;
                            rf_w_data_sel    = 2'd1;
                            cond_ld          = 1'b1;
                            cond_ld_data_sel = 1'b1;
                        end
                        OP_LDI: begin
                            mem_r_addr_sel = 2'd1;
                            ldi_reg_ld     = 1'b1;
                        end
                        OP_LEA: begin
                            rf_w_en          = 1'b1;
                            rf_w_data_sel    = 2'd3;
                            cond_ld          = 1'b1;
                            cond_ld_data_sel = 1'b1;
                        end
                        OP_ST: begin
                            mem_w_en       = 1'b1;
                            rf_r0_addr_sel = 1'b1;
                        end
                        OP_STR: begin
                            mem_w_en       = 1'b1;
                            mem_w_addr_sel = 2'd1;
                            rf_r0_addr_sel = 1'b1;
                            rf_r1_addr_sel = 1'b1;
                        end
                        OP_STI: begin
                            // Pointer fetch and store happen together: write address is mem read data.
                            mem_r_addr_sel = 2'd1;
                            mem_w_en       = 1'b1;
                            mem_w_addr_sel = 2'd2;
                            rf_r0_addr_sel = 1'b1;
                        end
                        OP_BR: begin
                            pc_ld = br_taken;
                        end
                        OP_JMP: begin
                            pc_ld          = 1'b1;
                            pc_ld_data_sel = 2'd1;
                        end
                        OP_JSR: begin
                            rf_w_en        = 1'b1;
                            rf_w_addr_sel  = 1'b1;
                            rf_w_data_sel  = 2'd2;
                            pc_ld          = 1'b1;
                            pc_ld_data_sel = ir[11] ? 2'd2 : 2'd1;
                        end
                        default: ;
                    endcase
                end
                S_EXEC2: begin
                    mem_r_addr_sel   = 2'd3;
                    rf_w_en          = 1'b1;
                    rf_w_data_sel    = 2'd1;
                    cond_ld          = 1'b1;
                    cond_ld_data_sel = 1'b1;
                    state_d          = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_punc_control.sv
// Directed bench for punc_control: walks each opcode through FETCH/DECODE/EXEC
// and compares every output against hand-derived expectations.
module tb_punc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic        n, z, p;
    logic        mem_w_en, mem_w_data_sel, rf_w_en, rf_r0_addr_sel, rf_r1_addr_sel;
    logic        rf_w_addr_sel, ir_ld, pc_ld, pc_clr, pc_inc, cond_ld, cond_ld_data_sel;
    logic        ldi_reg_ld, halted;
    logic [1:0]  mem_w_addr_sel, mem_r_addr_sel, rf_w_data_sel, pc_ld_data_sel;
    logic [2:0]  alu_sel;

    int tests = 0;
    int fails = 0;

    int e_mem_w_en, e_mem_w_addr_sel, e_mem_w_data_sel, e_mem_r_addr_sel, e_rf_w_en;
    int e_rf_r0_addr_sel, e_rf_r1_addr_sel, e_rf_w_data_sel, e_rf_w_addr_sel, e_ir_ld;
    int e_pc_ld, e_pc_clr, e_pc_inc, e_pc_ld_data_sel, e_alu_sel, e_cond_ld;
    int e_cond_ld_data_sel, e_ldi_reg_ld, e_halted;

    punc_control dut (
        .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
        .mem_w_en(mem_w_en), .mem_w_addr_sel(mem_w_addr_sel), .mem_w_data_sel(mem_w_data_sel),
        .mem_r_addr_sel(mem_r_addr_sel), .rf_w_en(rf_w_en), .rf_r0_addr_sel(rf_r0_addr_sel),
        .rf_r1_addr_sel(rf_r1_addr_sel), .rf_w_data_sel(rf_w_data_sel),
        .rf_w_addr_sel(rf_w_addr_sel), .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_clr(pc_clr),
        .pc_inc(pc_inc), .pc_ld_data_sel(pc_ld_data_sel), .alu_sel(alu_sel),
        .cond_ld(cond_ld), .cond_ld_data_sel(cond_ld_data_sel), .ldi_reg_ld(ldi_reg_ld),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_exp();
        e_mem_w_en = 0; e_mem_w_addr_sel = 0; e_mem_w_data_sel = 0; e_mem_r_addr_sel = 0;
        e_rf_w_en = 0; e_rf_r0_addr_sel = 0; e_rf_r1_addr_sel = 0; e_rf_w_data_sel = 0;
        e_rf_w_addr_sel = 0; e_ir_ld = 0; e_pc_ld = 0; e_pc_clr = 0; e_pc_inc = 0;
        e_pc_ld_data_sel = 0; e_alu_sel = 0; e_cond_ld = 0; e_cond_ld_data_sel = 0;
        e_ldi_reg_ld = 0; e_halted = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".mem_w_en"},         int'(mem_w_en),         e_mem_w_en);
        check({tag, ".mem_w_addr_sel"},   int'(mem_w_addr_sel),   e_mem_w_addr_sel);
        check({tag, ".mem_w_data_sel"},   int'(mem_w_data_sel),   e_mem_w_data_sel);
        check({tag, ".mem_r_addr_sel"},   int'(mem_r_addr_sel),   e_mem_r_addr_sel);
        check({tag, ".rf_w_en"},          int'(rf_w_en),          e_rf_w_en);
        check({tag, ".rf_r0_addr_sel"},   int'(rf_r0_addr_sel),   e_rf_r0_addr_sel);
        check({tag, ".rf_r1_addr_sel"},   int'(rf_r1_addr_sel),   e_rf_r1_addr_sel);
        check({tag, ".rf_w_data_sel"},    int'(rf_w_data_sel),    e_rf_w_data_sel);
        check({tag, ".rf_w_addr_sel"},    int'(rf_w_addr_sel),    e_rf_w_addr_sel);
        check({tag, ".ir_ld"},            int'(ir_ld),            e_ir_ld);
        check({tag, ".pc_ld"},            int'(pc_ld),            e_pc_ld);
        check({tag, ".pc_clr"},           int'(pc_clr),           e_pc_clr);
        check({tag, ".pc_inc"},           int'(pc_inc),           e_pc_inc);
        check({tag, ".pc_ld_data_sel"},   int'(pc_ld_data_sel),   e_pc_ld_data_sel);
        check({tag, ".alu_sel"},          int'(alu_sel),          e_alu_sel);
        check({tag, ".cond_ld"},          int'(cond_ld),          e_cond_ld);
        check({tag, ".cond_ld_data_sel"}, int'(cond_ld_data_sel), e_cond_ld_data_sel);
        check({tag, ".ldi_reg_ld"},       int'(ldi_reg_ld),       e_ldi_reg_ld);
        check({tag, ".halted"},           int'(halted),           e_halted);
    endtask

    // Expects the DUT in FETCH; checks FETCH and DECODE, leaves it in EXEC.
    task automatic begin_instr(input logic [15:0] v, input string tag);
        clr_exp(); e_ir_ld = 1; e_pc_inc = 1;
        check_all({tag, "/fetch"});
        ir = v;
        step();
        clr_exp();
        check_all({tag, "/decode"});
        step();
        clr_exp();
    endtask

    // Run one single-EXEC instruction whose EXEC expectations are set by the caller.
    task automatic exec_check(input string tag);
        check_all({tag, "/exec"});
        step();
    endtask

    initial begin
        rst = 1'b1; ir = 16'h0000; n = 0; z = 0; p = 0;
        step();
        clr_exp(); e_pc_clr = 1;
        check_all("reset");
        rst = 1'b0;
        #1;

        begin_instr(16'h1042, "add");
        e_rf_w_en = 1; e_cond_ld = 1; e_alu_sel = 0;
        exec_check("add");

        begin_instr(16'h1025, "addi");
        e_rf_w_en = 1; e_cond_ld = 1; e_alu_sel = 1;
        exec_check("addi");

        begin_instr(16'h5042, "and");
        e_rf_w_en = 1; e_cond_ld = 1; e_alu_sel = 3;
        exec_check("and");

        begin_instr(16'h5065, "andi");
        e_rf_w_en = 1; e_cond_ld = 1; e_alu_sel = 4;
        exec_check("andi");

        begin_instr(16'h907F, "not");
        e_rf_w_en = 1; e_cond_ld = 1; e_alu_sel = 2;
        exec_check("not");

        begin_instr(16'h2005, "ld");
        e_mem_r_addr_sel = 1; e_rf_w_en = 1; e_rf_w_data_sel = 1;
        e_cond_ld = 1; e_cond_ld_data_sel = 1;
        exec_check("ld");

        begin_instr(16'h6041, "ldr");
        e_mem_r_addr_sel = 2; e_rf_w_en = 1; e_rf_w_data_sel = 1;
        e_cond_ld = 1; e_cond_ld_data_sel = 1;
        exec_check("ldr");

        begin_instr(16'hA1FF, "ldi");
        e_mem_r_addr_sel = 1; e_ldi_reg_ld = 1;
        check_all("ldi/exec");
        step();
        clr_exp(); e_mem_r_addr_sel = 3; e_rf_w_en = 1; e_rf_w_data_sel = 1;
        e_cond_ld = 1; e_cond_ld_data_sel = 1;
        exec_check("ldi/exec2");

        begin_instr(16'hE005, "lea");
        e_rf_w_en = 1; e_rf_w_data_sel = 3; e_cond_ld = 1; e_cond_ld_data_sel = 1;
        exec_check("lea");

        begin_instr(16'h3005, "st");
        e_mem_w_en = 1; e_rf_r0_addr_sel = 1;
        exec_check("st");

        begin_instr(16'h7041, "str");
        e_mem_w_en = 1; e_mem_w_addr_sel = 1; e_rf_r0_addr_sel = 1; e_rf_r1_addr_sel = 1;
        exec_check("str");

        begin_instr(16'hB005, "sti");
        e_mem_r_addr_sel = 1; e_mem_w_en = 1; e_mem_w_addr_sel = 2; e_rf_r0_addr_sel = 1;
        exec_check("sti");

        z = 1;
        begin_instr(16'h0A05, "br_z");
        exec_check("br_z");
        z = 0; n = 1;
        begin_instr(16'h0A05, "br_n");
        e_pc_ld = 1;
        exec_check("br_n");
        n = 0; p = 1;
        begin_instr(16'h0A05, "br_p");
        e_pc_ld = 1;
        exec_check("br_p");
        p = 0;

        begin_instr(16'hC1C0, "jmp");
        e_pc_ld = 1; e_pc_ld_data_sel = 1;
        exec_check("jmp");

        begin_instr(16'h4803, "jsr");
        e_rf_w_en = 1; e_rf_w_addr_sel = 1; e_rf_w_data_sel = 2;
        e_pc_ld = 1; e_pc_ld_data_sel = 2;
        exec_check("jsr");

        begin_instr(16'h4080, "jsrr");
        e_rf_w_en = 1; e_rf_w_addr_sel = 1; e_rf_w_data_sel = 2;
        e_pc_ld = 1; e_pc_ld_data_sel = 1;
        exec_check("jsrr");

        begin_instr(16'h8000, "nop8");
        exec_check("nop8");
        begin_instr(16'hD000, "nopd");
        exec_check("nopd");

        // Reset during EXEC2 of LDI must suppress the register write.
        begin_instr(16'hA1FF, "ldi_rst");
        e_mem_r_addr_sel = 1; e_ldi_reg_ld = 1;
        check_all("ldi_rst/exec");
        step();
        rst = 1'b1;
        #1;
        clr_exp(); e_pc_clr = 1;
        check_all("ldi_rst/exec2_rst");
        step();
        rst = 1'b0;
        #1;

        // HALT: DECODE goes to HALT, which must hold until reset.
        clr_exp(); e_ir_ld = 1; e_pc_inc = 1;
        check_all("halt/fetch");
        ir = 16'hF025;
        step();
        clr_exp();
        check_all("halt/decode");
        for (int i = 0; i < 10; i++) begin
            step();
            clr_exp(); e_halted = 1;
            check_all($sformatf("halt/hold%0d", i));
        end
        rst = 1'b1;
        #1;
        clr_exp(); e_pc_clr = 1;
        check_all("halt/rst");
        step();
        rst = 1'b0;
        #1;
        clr_exp(); e_ir_ld = 1; e_pc_inc = 1;
        check_all("halt/refetch");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/punc_control.md
PUNC_CONTROL -- requirements
Module: punc_control

Interface
REQ-001 clk  in  1  clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 ir  in  16  instruction register; opcode ir[15:12].
REQ-004 n, z, p  in  1 each  condition codes.
REQ-005 mem_w_en  out  1  memory write strobe.
REQ-006 mem_w_addr_sel  out  2  0=PC+sext9, 1=RF_r1+sext6, 2=mem read data.
REQ-007 mem_w_data_sel  out  1  0=RF_r0 data, 1=mem read data.
REQ-008 mem_r_addr_sel  out  2  0=PC, 1=PC+sext9, 2=RF_r0+sext6, 3=ldi_reg.
REQ-009 rf_w_en  out  1  register-file write strobe.
REQ-010 rf_r0_addr_sel  out  1  0=ir[8:6], 1=ir[11:9].
REQ-011 rf_r1_addr_sel  out  1  0=ir[2:0], 1=ir[8:6].
REQ-012 rf_w_data_sel  out  2  0=ALU, 1=mem read data, 2=PC, 3=PC+sext9.
REQ-013 rf_w_addr_sel  out  1  0=ir[11:9], 1=R7.
REQ-014 ir_ld  out  1  load IR from memory read data.
REQ-015 pc_ld / pc_clr / pc_inc  out  1 each  PC load, clear, increment.
REQ-016 pc_ld_data_sel  out  2  0=PC+sext9, 1=RF_r0, 2=PC+sext11.
REQ-017 alu_sel  out  3  0=ADD, 1=ADD_I, 2=NOT, 3=AND, 4=AND_I, 5=PASS.
REQ-018 cond_ld  out  1  load n/z/p; cond_ld_data_sel  out  1  0=ALU, 1=RF write data.
REQ-019 ldi_reg_ld  out  1  load LDI pointer register.
REQ-020 halted  out  1  high while in HALT state.

Function
REQ-021 States: FETCH, DECODE, EXEC, EXEC2, HALT; state register only sequential element; all outputs combinational from state and ir.
REQ-022 Default every cycle: all strobes 0, all selects 0.
REQ-023 FETCH: mem_r_addr_sel=0, ir_ld=1, pc_inc=1; -> DECODE.
REQ-024 DECODE: no strobes; -> HALT if opcode 1111, else -> EXEC.
REQ-025 EXEC -> FETCH for all opcodes except LDI (1010) -> EXEC2; EXEC2 -> FETCH.
REQ-026 ADD 0001 / AND 0101: r0_sel=0, r1_sel=0; alu_sel ADD/AND if ir[5]=0, ADD_I/AND_I if ir[5]=1; rf_w_en=1, w_data=ALU, w_addr=ir[11:9]; cond_ld=1, cond sel ALU.
REQ-027 NOT 1001: alu_sel=NOT, r0_sel=0; write and cond as ADD.
REQ-028 LD 0010: mem_r_addr_sel=1, rf_w_en, w_data=MEM, cond_ld, cond sel RF.
REQ-029 LDR 0110: mem_r_addr_sel=2, r0_sel=0; write and cond as LD.
REQ-030 LDI: EXEC mem_r_addr_sel=1, ldi_reg_ld=1; EXEC2 mem_r_addr_sel=3, rf_w_en, w_data=MEM, cond_ld, cond sel RF.
REQ-031 LEA 1110: rf_w_en, w_data=PC+sext9, cond_ld, cond sel RF.
REQ-032 ST 0011: mem_w_en, w_addr_sel=0, w_data_sel=0, r0_sel=1.
REQ-033 STR 0111: mem_w_en, w_addr_sel=1, r1_sel=1, w_data_sel=0, r0_sel=1.
REQ-034 STI 1011: single cycle; mem_r_addr_sel=1, mem_w_en, w_addr_sel=2, w_data_sel=0, r0_sel=1.
REQ-035 BR 0000: pc_ld=1, sel 0, iff (n&ir[11])|(z&ir[10])|(p&ir[9]); else no strobe.
REQ-036 JMP/RET 1100: pc_ld, sel 1, r0_sel=0.
REQ-037 JSR/JSRR 0100: rf_w_en, w_addr=R7, w_data=PC; pc_ld with sel 2 if ir[11]=1, else sel 1 with r0_sel=0 (base read precedes R7 write in same cycle).
REQ-038 Opcodes 1000, 1101: no strobes in EXEC (NOP).
REQ-039 HALT: all strobes 0, halted=1; remains until rst.

Reset
REQ-040 rst=1: next state FETCH; pc_clr=1 combinationally while rst=1; all other strobes 0; halted=0.
REQ-041 rst mid-instruction (any state, incl. EXEC2): aborts; no mem/rf write in reset cycle.

Verification
REQ-042 rst 1 cycle then ir=16'h1042 (ADD R0,R1,R2): FETCH ir_ld/pc_inc -> DECODE -> EXEC rf_w_en, alu_sel=0, cond_ld -> FETCH; 3 cycles.
REQ-043 ir=16'hA1FF (LDI): EXEC ldi_reg_ld, r_sel=1; EXEC2 r_sel=3, rf_w_en, w_data=1; 4 cycles total.
REQ-044 ir=16'h0A05 (BRnp) with z=1: pc_ld=0; with n=1: pc_ld=1, sel 0.
REQ-045 ir=16'h4803 (JSR): EXEC rf_w_en, w_addr_sel=1, w_data_sel=2, pc_ld, sel 2.
REQ-046 ir=16'hF025: DECODE -> HALT, halted=1 held 10 cycles; rst -> FETCH, pc_clr=1 during rst.
REQ-047 rst asserted in EXEC2 of LDI: rf_w_en=0 that cycle; next state FETCH.
